et_bpc_sng: RTL

ET_BPC_SNG -- requirements
Module: et_bpc_sng

---
 rtl/et_bpc_sng.sv | 128 ++++++++++++
 1 files changed

// File: rtl/et_bpc_sng.sv
// et_bpc_sng -- bit-parallel stochastic number generator.
//
// Emits a 2^L-bit stochastic stream per channel. A free-running TW-bit counter
// is sliced into N W-bit fields; each channel compares the bit-reversed field
// (a van der Corput low-discrepancy sequence) against its latched binary
// operand. Low counter bits are also exported as constant 0.5 streams.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a new stream (only accepted while idle)
//   len_log2   stream length exponent L (clamped to TW)
//   corr       per channel: 1 = reuse slice 0 (correlated), 0 = own slice
//   Bxs        per-channel binary operands
//   out_ready  consumer accepts the current bit vector
//   busy       stream in progress
//   out_valid  Xs/Xcs carry a valid stream bit
//   Xs         stochastic bits, one per channel
//   Xcs        constant 0.5-probability streams
//   done       one-cycle pulse after the final bit transfers
module et_bpc_sng #(
    parameter  int W  = 8,
    parameter  int N  = 2,
    parameter  int NC = 1,
    localparam int TW = N * W,
    localparam int LW = $clog2(TW + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] len_log2,
    input  logic [N-1:0]  corr,
    input  logic [W-1:0]  Bxs [N],
    input  logic          out_ready,
    output logic          busy,
    output logic          out_valid,
    output logic [N-1:0]  Xs,
    output logic [NC-1:0] Xcs,
    output logic          done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   cnt;
    logic [W-1:0]    bx_q [N];
    logic [N-1:0]    corr_q;
    logic [LW-1:0]   lq;
    logic [LW-1:0]   lq_clamp;
    logic [TW-1:0]   mask;
    logic            xfer;
    logic            last;
    logic            load;
    logic [W-1:0]    slice [N];
    logic [W-1:0]    rev   [N];

    assign lq_clamp = (len_log2 > LW'(TW)) ? LW'(TW) : len_log2;
    assign busy     = (state == RUN);
    assign out_valid = busy;
    assign xfer     = busy && out_ready;
    assign load     = (state == IDLE) && start;

    // M = 2^Lq - 1 built bitwise so Lq = TW yields all-ones without a wider shift.
    always_comb begin
        mask = '0;
        for (int unsigned k = 0; k < TW; k++) begin
            if (k < 32'(lq)) begin
                mask[k] = 1'b1;
            end
        end
    end

    assign last = ((cnt & mask) == mask);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)        state_nxt = RUN;
            RUN:  if (xfer && last) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            bx_q   <= '{default: '0};
            corr_q <= '0;
            lq     <= '0;
            done   <= 1'b0;
        end else begin
            done <= xfer && last;
            if (load) begin
                bx_q   <= Bxs;
                corr_q <= corr;
                lq     <= lq_clamp;
                cnt    <= '0;
            end else if (xfer) begin
                cnt <= cnt + TW'(1);
            end
        end
    end

    always_comb begin
        Xs = '0;
        for (int unsigned i = 0; i < N; i++) begin
            slice[i] = corr_q[i] ? cnt[0 +: W] : cnt[i*W +: W];
            for (int unsigned b = 0; b < W; b++) begin
                rev[i][b] = slice[i][W-1-b];
            end
            Xs[i] = busy && (rev[i] < bx_q[i]);
        end
    end

    assign Xcs = busy ? cnt[NC-1:0] : '0;

endmodule
